ring_injection_controller: RTL and testbench

RING_INJECTION_CONTROLLER -- requirements
Module: ring_injection_controller

---
 rtl/ring_injection_controller.sv | 185 ++++++++++++++++++
 tb/tb_ring_injection_controller.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ring_injection_controller.sv
// ring_injection_controller: seeds a ring with one {cc_id, pc} override word per
// enabled character context, then waits for the ring to settle and drain.
// Optional drain watchdog: define RING_INJECTION_DRAIN_TIMEOUT_EN.
module ring_injection_controller #(
  parameter int PC_WIDTH      = 8,
  parameter int CC_ID_BITS    = 1,
  parameter int TIMEOUT_WIDTH = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [PC_WIDTH-1:0]            start_pc,
  input  logic [(2**CC_ID_BITS)-1:0]     cc_enable,
  output logic [PC_WIDTH+CC_ID_BITS-1:0] override_data,
  output logic                           override_valid,
  input  logic                           override_ready,
  input  logic                           any_bb_running,
  input  logic                           any_bb_accept,
  input  logic                           all_bb_full,
  output logic                           busy,
  output logic                           done,
  output logic                           accepted,
  output logic                           timeout
);

  localparam int NUM_CC = 2 ** CC_ID_BITS;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INJECT,
    ST_SETTLE,
    ST_DRAIN,
    ST_DONE
  } state_t;

  state_t                state_q;
  logic [PC_WIDTH-1:0]   pc_q;
  logic [CC_ID_BITS-1:0] cc_id_q;
  logic [NUM_CC-1:0]     pend_q;      // contexts whose word has not yet transferred
  logic                  valid_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  accepted_q;
  logic                  timeout_q;
  logic                  settle_q;    // second SETTLE cycle marker

`ifdef RING_INJECTION_DRAIN_TIMEOUT_EN
  localparam logic [TIMEOUT_WIDTH-1:0] DRAIN_ONE  = {{(TIMEOUT_WIDTH-1){1'b0}}, 1'b1};
  // Count value seen in the DRAIN cycle whose increment would reach all-ones
  localparam logic [TIMEOUT_WIDTH-1:0] DRAIN_LAST = ~DRAIN_ONE;
  logic [TIMEOUT_WIDTH-1:0] drain_cnt_q;
`endif

  logic [NUM_CC-1:0]     pend_after_d;
  logic [CC_ID_BITS-1:0] next_id_d;
  logic                  xfer_d;

  // Lowest set bit of a context mask; ascending cc_id issue order
  function automatic logic [CC_ID_BITS-1:0] lowest_id(input logic [NUM_CC-1:0] mask);
    logic [CC_ID_BITS-1:0] id;
    id = '0;
    for (int i = NUM_CC - 1; i >= 0; i--) begin
      if (mask[i]) id = i[CC_ID_BITS-1:0];
    end
    return id;
  endfunction

  // Remaining contexts once the presented word transfers, and the next id to present
  always_comb begin
    pend_after_d          = pend_q;
    pend_after_d[cc_id_q] = 1'b0;
    next_id_d             = lowest_id(pend_after_d);
    xfer_d                = valid_q & override_ready;
  end

  // Controller FSM with registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      pc_q        <= '0;
      cc_id_q     <= '0;
      pend_q      <= '0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      accepted_q  <= 1'b0;
      timeout_q   <= 1'b0;
      settle_q    <= 1'b0;
`ifdef RING_INJECTION_DRAIN_TIMEOUT_EN
      drain_cnt_q <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            pc_q       <= start_pc;
            accepted_q <= 1'b0;
            timeout_q  <= 1'b0;
            if (cc_enable == '0) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_INJECT;
              busy_q  <= 1'b1;
              pend_q  <= cc_enable;
              cc_id_q <= lowest_id(cc_enable);
              // A new word is only offered while the ring has room
              valid_q <= ~all_bb_full;
            end
          end
        end

        ST_INJECT: begin
          if (any_bb_accept) accepted_q <= 1'b1;
          if (valid_q) begin
            if (xfer_d) begin
              pend_q <= pend_after_d;
              if (pend_after_d == '0) begin
                valid_q  <= 1'b0;
                settle_q <= 1'b0;
                state_q  <= ST_SETTLE;
              end else begin
                cc_id_q <= next_id_d;
                valid_q <= ~all_bb_full;
              end
            end
          end else begin
            valid_q <= ~all_bb_full;
          end
        end

        ST_SETTLE: begin
          if (any_bb_accept) accepted_q <= 1'b1;
          if (settle_q) begin
            state_q     <= ST_DRAIN;
`ifdef RING_INJECTION_DRAIN_TIMEOUT_EN
            drain_cnt_q <= '0;
`endif
          end else begin
            settle_q <= 1'b1;
          end
        end

        ST_DRAIN: begin
          if (any_bb_accept) accepted_q <= 1'b1;
          if (!any_bb_running) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end
`ifdef RING_INJECTION_DRAIN_TIMEOUT_EN
          else if (drain_cnt_q == DRAIN_LAST) begin
            drain_cnt_q <= drain_cnt_q + DRAIN_ONE;
            timeout_q   <= 1'b1;
            state_q     <= ST_DONE;
            done_q      <= 1'b1;
            busy_q      <= 1'b0;
          end else begin
            drain_cnt_q <= drain_cnt_q + DRAIN_ONE;
          end
`endif
        end

        ST_DONE: begin
          state_q <= ST_IDLE;
        end

        default: begin
          state_q <= ST_IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign override_data  = {cc_id_q, pc_q};
  assign override_valid = valid_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign accepted       = accepted_q;
  assign timeout        = timeout_q;

endmodule

// File: tb/tb_ring_injection_controller.sv
// tb_ring_injection_controller: randomized and directed stimulus for the ring
// injection controller, checked against a queue-based transaction model.
module tb_ring_injection_controller;

  localparam int PCW    = 8;
  localparam int CCB    = 1;
  localparam int NCC    = 2 ** CCB;
  localparam int DW     = PCW + CCB;
  localparam int BUDGET = 200;
`ifdef RING_INJECTION_DRAIN_TIMEOUT_EN
  localparam int TW     = 4;
  localparam bit TO_EN  = 1'b1;
`else
  localparam int TW     = 16;
  localparam bit TO_EN  = 1'b0;
`endif

  logic           clk;
  logic           rst;
  logic           start;
  logic [PCW-1:0] start_pc;
  logic [NCC-1:0] cc_enable;
  logic [DW-1:0]  override_data;
  logic           override_valid;
  logic           override_ready;
  logic           any_bb_running;
  logic           any_bb_accept;
  logic           all_bb_full;
  logic           busy;
  logic           done;
  logic           accepted;
  logic           timeout;

  int n_vec;
  int n_err;
  int n_xfer;

  // Per-cycle record of inputs driven and outputs seen, indexed from the start cycle
  bit          rdy_a  [BUDGET];
  bit          full_a [BUDGET];
  bit          acc_a  [BUDGET];
  bit          run_a  [BUDGET];
  bit          obs_v  [BUDGET];
  logic [DW-1:0] obs_d [BUDGET];
  bit          obs_done [BUDGET];
  bit          obs_acc  [BUDGET];
  bit          obs_to   [BUDGET];

  ring_injection_controller #(
    .PC_WIDTH      (PCW),
    .CC_ID_BITS    (CCB),
    .TIMEOUT_WIDTH (TW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .start_pc       (start_pc),
    .cc_enable      (cc_enable),
    .override_data  (override_data),
    .override_valid (override_valid),
    .override_ready (override_ready),
    .any_bb_running (any_bb_running),
    .any_bb_accept  (any_bb_accept),
    .all_bb_full    (all_bb_full),
    .busy           (busy),
    .done           (done),
    .accepted       (accepted),
    .timeout        (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    start          = 1'b0;
    override_ready = 1'b0;
    all_bb_full    = 1'b0;
    any_bb_accept  = 1'b0;
    any_bb_running = 1'b0;
  endtask

  // Ring-side behaviour for cycle rel of a transaction
  task automatic drive_misc(input int mode, input int rel);
    bit r, f, a, run;
    case (mode)
      0: begin
        r   = ($urandom % 4) != 0;
        f   = ($urandom % 4) == 0;
        a   = ($urandom % 8) == 0;
        run = ($urandom % 4) != 0;
      end
      1: begin r = 1; f = 0; a = 0; run = 0; end
      2: begin r = 1; f = (rel <= 3); a = 0; run = 0; end
      3: begin r = (rel >= 4); f = 0; a = 0; run = 0; end
      4: begin r = 1; f = 0; a = (rel == 5); run = (rel < 15); end
      default: begin r = 1; f = 0; a = 0; run = 1; end
    endcase
    override_ready = r;
    all_bb_full    = f;
    any_bb_accept  = a;
    any_bb_running = run;
    rdy_a[rel]  = r;
    full_a[rel] = f;
    acc_a[rel]  = a;
    run_a[rel]  = run;
  endtask

  // One start request followed cycle by cycle against the transaction model
  task automatic run_txn(input logic [PCW-1:0] pc, input logic [NCC-1:0] en, input int mode);
    logic [DW-1:0] q[$];
    bit pv, ev, eacc, eto, fin;
    int drain_start, done_rel;
    for (int i = 0; i < BUDGET; i++) begin
      obs_v[i] = 0; obs_d[i] = '0; obs_done[i] = 0; obs_acc[i] = 0; obs_to[i] = 0;
    end
    @(negedge clk);
    start     = 1'b1;
    start_pc  = pc;
    cc_enable = en;
    drive_misc(mode, 0);
    q.delete();
    for (int i = 0; i < NCC; i++) if (en[i]) q.push_back({i[CCB-1:0], pc});
    done_rel    = (q.size() == 0) ? 1 : -1;
    drain_start = -1;
    pv = 0; ev = 0; eacc = 0; eto = 0; fin = 0; n_xfer = 0;
    for (int rel = 1; rel < BUDGET; rel++) begin
      @(negedge clk);
      if (rel > 1 && acc_a[rel-1]) eacc = 1;
      if (rel > 1 && obs_v[rel-1] && rdy_a[rel-1]) n_xfer++;
      // Expected offer: words go out in queue order, a held word stays until taken,
      // and a fresh offer needs a non-full ring in the preceding cycle
      if (done_rel < 0 && drain_start < 0) begin
        if (rel == 1) ev = !full_a[0];
        else if (pv && rdy_a[rel-1]) begin
          void'(q.pop_front());
          if (q.size() == 0) begin
            drain_start = rel + 2;
            ev = 0;
          end else ev = !full_a[rel-1];
        end else if (pv) ev = 1;
        else ev = !full_a[rel-1];
      end else ev = 0;
      if (done_rel < 0 && drain_start >= 0 && rel - 1 >= drain_start) begin
        if (!run_a[rel-1]) done_rel = rel;
        else if (TO_EN && (rel - drain_start) == (1 << TW) - 1) begin
          done_rel = rel;
          eto = 1;
        end
      end
      obs_v[rel]    = override_valid;
      obs_d[rel]    = override_data;
      obs_done[rel] = done;
      obs_acc[rel]  = accepted;
      obs_to[rel]   = timeout;
      check_val("valid", 32'(override_valid), 32'(ev));
      if (ev) check_val("data", 32'(override_data), 32'(q[0]));
      check_val("busy", 32'(busy), 32'(rel != done_rel));
      check_val("done", 32'(done), 32'(rel == done_rel));
      check_val("accepted", 32'(accepted), 32'(eacc));
      check_val("timeout", 32'(timeout), 32'(eto && rel == done_rel));
      pv = ev;
      if (rel == done_rel) begin
        idle_inputs();
        @(negedge clk);
        check_val("idle_busy", 32'(busy), 32'(0));
        check_val("idle_done", 32'(done), 32'(0));
        check_val("idle_valid", 32'(override_valid), 32'(0));
        check_val("idle_acc", 32'(accepted), 32'(eacc));
        check_val("idle_to", 32'(timeout), 32'(eto));
        fin = 1;
        break;
      end
      // Requests while busy must be ignored
      start     = (mode == 0) && (($urandom % 8) == 0);
      start_pc  = PCW'($urandom);
      cc_enable = NCC'($urandom);
      drive_misc(mode, rel);
    end
    if (!fin) begin
      idle_inputs();
      check_val("budget", 32'(0), 32'(1));
    end
    check_val("xfers", 32'(n_xfer), 32'($countones(en)));
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst   = 1'b1;
    start_pc  = '0;
    cc_enable = '0;
    idle_inputs();
    repeat (2) @(negedge clk);
    check_val("rst_valid", 32'(override_valid), 32'(0));
    check_val("rst_data", 32'(override_data), 32'(0));
    check_val("rst_busy", 32'(busy), 32'(0));
    check_val("rst_done", 32'(done), 32'(0));
    check_val("rst_acc", 32'(accepted), 32'(0));
    check_val("rst_to", 32'(timeout), 32'(0));
    rst = 1'b0;
    @(negedge clk);

    // Back-to-back injection with a ready ring
    run_txn(8'h05, 2'b11, 1);
    check_val("b2b_v1", 32'(obs_v[1]), 32'(1));
    check_val("b2b_d1", 32'(obs_d[1]), 32'h005);
    check_val("b2b_d2", 32'(obs_d[2]), 32'h105);
    check_val("b2b_v3", 32'(obs_v[3]), 32'(0));

    // Ring full holds off the first offer
    run_txn(8'h05, 2'b11, 2);
    check_val("full_v4", 32'(obs_v[4]), 32'(0));
    check_val("full_v5", 32'(obs_v[5]), 32'(1));
    check_val("full_d5", 32'(obs_d[5]), 32'h005);

    // Ready withheld: word held stable, single transfer
    run_txn(8'hA7, 2'b01, 3);
    for (int r = 1; r <= 4; r++) begin
      check_val("hold_v", 32'(obs_v[r]), 32'(1));
      check_val("hold_d", 32'(obs_d[r]), 32'h0A7);
    end
    check_val("hold_v5", 32'(obs_v[5]), 32'(0));
    check_val("hold_n", 32'(n_xfer), 32'(1));

    // Only context 1 enabled: id 0 skipped without a gap
    run_txn(8'h3E, 2'b10, 1);
    check_val("skip_d1", 32'(obs_d[1]), 32'h13E);

    // No contexts: immediate done
    run_txn(8'h77, 2'b00, 1);
    check_val("empty_done", 32'(obs_done[1]), 32'(1));
    check_val("empty_acc", 32'(obs_acc[1]), 32'(0));

    // Accept during drain, ring idles 10 cycles later
    run_txn(8'h42, 2'b01, 4);
    check_val("drain_done", 32'(obs_done[16]), 32'(1));
    check_val("drain_acc", 32'(obs_acc[16]), 32'(1));

`ifdef RING_INJECTION_DRAIN_TIMEOUT_EN
    run_txn(8'h19, 2'b01, 5);
    check_val("wd_done", 32'(obs_done[19]), 32'(1));
    check_val("wd_to", 32'(obs_to[19]), 32'(1));
`endif

    for (int k = 0; k < 40; k++) begin
      run_txn(PCW'($urandom), NCC'($urandom), 0);
    end

    // Reset while a word is being offered
    @(negedge clk);
    start = 1'b1; start_pc = 8'h3C; cc_enable = 2'b11;
    override_ready = 1'b0; all_bb_full = 1'b0; any_bb_accept = 1'b0; any_bb_running = 1'b1;
    @(negedge clk);
    start = 1'b0;
    any_bb_accept = 1'b1;
    check_val("pre_rst_v", 32'(override_valid), 32'(1));
    @(negedge clk);
    any_bb_accept = 1'b0;
    check_val("pre_rst_acc", 32'(accepted), 32'(1));
    #2 rst = 1'b1;
    #1;
    check_val("arst_valid", 32'(override_valid), 32'(0));
    check_val("arst_data", 32'(override_data), 32'(0));
    check_val("arst_busy", 32'(busy), 32'(0));
    check_val("arst_acc", 32'(accepted), 32'(0));
    check_val("arst_done", 32'(done), 32'(0));
    check_val("arst_to", 32'(timeout), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    override_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check_val("post_rst_v", 32'(override_valid), 32'(0));
      check_val("post_rst_busy", 32'(busy), 32'(0));
    end
    idle_inputs();
    run_txn(8'h11, 2'b11, 1);
    check_val("post_rst_d1", 32'(obs_d[1]), 32'h011);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
